// File: rtl/csa_key_sweep.sv
// Host-side feeder/collector for the CSA engine FIFOs: issues 5-word job records over a ck sweep
// and drains 7-word result records, comparing each result against a target.
module csa_key_sweep #(
  parameter int unsigned AXI_DATA_WIDTH     = 32,
  parameter int unsigned CSA_CALC_IN_WIDTH  = 48,
  parameter int unsigned CSA_CALC_OUT_WIDTH = 64,
  parameter int unsigned RD_LATENCY         = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [AXI_DATA_WIDTH-1:0]     cfg_block,
  input  logic [CSA_CALC_IN_WIDTH-1:0]  cfg_ck_base,
  input  logic [AXI_DATA_WIDTH-1:0]     cfg_times,
  input  logic [AXI_DATA_WIDTH-1:0]     cfg_times_start,
  input  logic [31:0]                   cfg_job_count,
  input  logic [CSA_CALC_OUT_WIDTH-1:0] cfg_target,
  input  logic                          cfg_stop_on_hit,
  input  logic                          csa_in_full,
  output logic                          csa_in_wen,
  output logic [AXI_DATA_WIDTH-1:0]     csa_in_wdata,
  input  logic                          csa_out_r_ready,
  output logic                          csa_out_ren,
  input  logic [AXI_DATA_WIDTH-1:0]     csa_out_rdata,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   jobs_sent,
  output logic [31:0]                   results_received,
  output logic                          hit,
  output logic [31:0]                   hit_count,
  output logic [CSA_CALC_IN_WIDTH-1:0]  hit_ck
);

  typedef enum logic [1:0] {WIdle, WCheck, WWr} w_state_e;
  typedef enum logic [1:0] {RIdle, RRd, RWait, RCmp} r_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic [2:0] w_idx_q, w_idx_d;
  logic [2:0] r_idx_q, r_idx_d;
  logic [2:0] cap_idx_q;
  logic [RD_LATENCY-1:0] ren_pipe_q;

  logic                          busy_q, done_q, abort_q;
  logic [AXI_DATA_WIDTH-1:0]     block_q, times_q, times_start_q;
  logic [31:0]                   job_count_q;
  logic [CSA_CALC_OUT_WIDTH-1:0] target_q;
  logic                          stop_on_hit_q;
  logic [CSA_CALC_IN_WIDTH-1:0]  ck_q;
  logic [31:0]                   js_q, rr_q, hit_count_q;
  logic                          hit_q;
  logic [CSA_CALC_IN_WIDTH-1:0]  hit_ck_q;
  logic [CSA_CALC_IN_WIDTH-1:0]  res_ck_q;
  logic [CSA_CALC_OUT_WIDTH-1:0] res_out_q;

  logic        start_ok, rec_done, cap_valid, cmp_hit, hit_next, stop_issue;
  logic        read_go, end_cond, busy_d;
  logic [31:0] rr_next;

  assign start_ok  = start & ~busy_q;
  assign rec_done  = (w_state_q == WWr) && (w_idx_q == 3'd4);
  assign cap_valid = ren_pipe_q[RD_LATENCY-1];
  assign cmp_hit   = (r_state_q == RCmp) && (res_out_q == target_q);
  // A hit being recorded this cycle already blocks a new record in the same cycle.
  assign hit_next   = hit_q | cmp_hit;
  assign stop_issue = (js_q == job_count_q) | abort_q | abort | (stop_on_hit_q & hit_next);
  assign read_go    = busy_q && (rr_q < js_q) && csa_out_r_ready;
  assign rr_next    = (r_state_q == RCmp) ? sat_inc(rr_q) : rr_q;
  // The writer never enters WIdle while finishing a record, so js_q is final here.
  assign end_cond   = busy_q && (w_state_d == WIdle) && (rr_next == js_q);
  assign busy_d     = start_ok ? 1'b1 : (end_cond ? 1'b0 : busy_q);

  // Writer FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= WIdle;
      w_idx_q   <= 3'd0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    unique case (w_state_q)
      WIdle: if (start_ok) w_state_d = WCheck;
      WCheck: begin
        if (stop_issue) begin
          w_state_d = WIdle;
        end else if (!csa_in_full) begin
          w_state_d = WWr;
          w_idx_d   = 3'd0;
        end
      end
      WWr: begin
        if (w_idx_q == 3'd4) w_state_d = WCheck;
        else                 w_idx_d   = w_idx_q + 3'd1;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    csa_in_wen   = (w_state_q == WWr);
    csa_in_wdata = '0;
    if (w_state_q == WWr) begin
      unique case (w_idx_q)
        3'd0:    csa_in_wdata = block_q;
        3'd1:    csa_in_wdata = ck_q[31:0];
        3'd2:    csa_in_wdata = {16'h0, ck_q[CSA_CALC_IN_WIDTH-1:32]};
        3'd3:    csa_in_wdata = times_q;
        3'd4:    csa_in_wdata = times_start_q;
        default: csa_in_wdata = '0;
      endcase
    end
  end

  // Reader FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= RIdle;
      r_idx_q   <= 3'd0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    unique case (r_state_q)
      RIdle: begin
        if (read_go) begin
          r_state_d = RRd;
          r_idx_d   = 3'd0;
        end
      end
      RRd: begin
        if (r_idx_q == 3'd6) r_state_d = RWait;
        else                 r_idx_d   = r_idx_q + 3'd1;
      end
      RWait:   if (cap_valid && (cap_idx_q == 3'd6)) r_state_d = RCmp;
      RCmp:    r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    csa_out_ren = (r_state_q == RRd);
  end

  // Read-data capture: the strobe is delayed by the FIFO read latency to mark valid words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren_pipe_q <= '0;
      cap_idx_q  <= 3'd0;
      res_ck_q   <= '0;
      res_out_q  <= '0;
    end else begin
      ren_pipe_q[0] <= csa_out_ren;
      for (int i = 1; i < RD_LATENCY; i++) ren_pipe_q[i] <= ren_pipe_q[i-1];
      if ((r_state_q == RIdle) && read_go) begin
        cap_idx_q <= 3'd0;
      end else if (cap_valid) begin
        cap_idx_q <= cap_idx_q + 3'd1;
        unique case (cap_idx_q)
          3'd1: res_ck_q[31:0] <= csa_out_rdata;
          3'd2: res_ck_q[CSA_CALC_IN_WIDTH-1:32] <= csa_out_rdata[CSA_CALC_IN_WIDTH-33:0];
          3'd5: res_out_q[31:0] <= csa_out_rdata;
          3'd6: res_out_q[CSA_CALC_OUT_WIDTH-1:32] <= csa_out_rdata;
          default: ;
        endcase
      end
    end
  end

  // Sweep configuration, counters and hit statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
      block_q       <= '0;
      times_q       <= '0;
      times_start_q <= '0;
      job_count_q   <= '0;
      target_q      <= '0;
      stop_on_hit_q <= 1'b0;
      ck_q          <= '0;
      js_q          <= '0;
      rr_q          <= '0;
      hit_q         <= 1'b0;
      hit_count_q   <= '0;
      hit_ck_q      <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= end_cond;
      if (start_ok) begin
        block_q       <= cfg_block;
        times_q       <= cfg_times;
        times_start_q <= cfg_times_start;
        job_count_q   <= cfg_job_count;
        target_q      <= cfg_target;
        stop_on_hit_q <= cfg_stop_on_hit;
        ck_q          <= cfg_ck_base;
        abort_q       <= 1'b0;
        js_q          <= '0;
        rr_q          <= '0;
        hit_q         <= 1'b0;
        hit_count_q   <= '0;
        hit_ck_q      <= '0;
      end else begin
        if (abort && busy_q) abort_q <= 1'b1;
        if (rec_done) begin
          js_q <= sat_inc(js_q);
          ck_q <= ck_q + 48'd1;
        end
        if (r_state_q == RCmp) begin
          rr_q <= rr_next;
          if (cmp_hit) begin
            hit_q       <= 1'b1;
            hit_count_q <= sat_inc(hit_count_q);
            if (!hit_q) hit_ck_q <= res_ck_q;
          end
        end
      end
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign jobs_sent        = js_q;
  assign results_received = rr_q;
  assign hit              = hit_q;
  assign hit_count        = hit_count_q;
  assign hit_ck           = hit_ck_q;

endmodule

// File: tb/tb_csa_key_sweep.sv
// Self-checking bench for csa_key_sweep: loopback engine model with fixed read latency, a sweep
// model checking every written word and the end-of-sweep statistics, plus directed literals.
module tb_csa_key_sweep;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [31:0] cfg_block, cfg_times, cfg_times_start, cfg_job_count;
  logic [47:0] cfg_ck_base;
  logic [63:0] cfg_target;
  logic        cfg_stop_on_hit;
  logic        csa_in_full;
  logic        csa_in_wen;
  logic [31:0] csa_in_wdata;
  logic        csa_out_r_ready;
  logic        csa_out_ren;
  logic [31:0] csa_out_rdata;
  logic        busy, done, hit;
  logic [31:0] jobs_sent, results_received, hit_count;
  logic [47:0] hit_ck;

  csa_key_sweep dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .cfg_block        (cfg_block),
    .cfg_ck_base      (cfg_ck_base),
    .cfg_times        (cfg_times),
    .cfg_times_start  (cfg_times_start),
    .cfg_job_count    (cfg_job_count),
    .cfg_target       (cfg_target),
    .cfg_stop_on_hit  (cfg_stop_on_hit),
    .csa_in_full      (csa_in_full),
    .csa_in_wen       (csa_in_wen),
    .csa_in_wdata     (csa_in_wdata),
    .csa_out_r_ready  (csa_out_r_ready),
    .csa_out_ren      (csa_out_ren),
    .csa_out_rdata    (csa_out_rdata),
    .busy             (busy),
    .done             (done),
    .jobs_sent        (jobs_sent),
    .results_received (results_received),
    .hit              (hit),
    .hit_count        (hit_count),
    .hit_ck           (hit_ck)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sweep model state (latched at an accepted start)
  logic [47:0] m_base;
  logic [31:0] m_block, m_times, m_times_start;
  logic [63:0] m_target;
  logic        m_stop_on_hit;
  logic [47:0] hit_set[$];
  logic [47:0] sent_cks[$];
  logic [31:0] wr_log[$];
  logic [31:0] cur_rec[5];
  int          rec_len;
  logic [31:0] out_fifo[$];
  logic [31:0] s1, s2;
  logic        prev_full, prev_wen, abort_seen;
  int          done_pulses, cycle, start_cycle, done_cycle;
  logic [47:0] rck;
  logic [63:0] rout;
  int          exp_hits;
  logic [47:0] exp_hit_ck;

  function automatic bit is_hit_ck(input logic [47:0] ck);
    foreach (hit_set[i]) if (hit_set[i] == ck) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_word(input int n, input int k);
    logic [47:0] ck;
    ck = m_base + 48'(n);
    case (k)
      0:       return m_block;
      1:       return ck[31:0];
      2:       return {16'h0, ck[47:32]};
      3:       return m_times;
      default: return m_times_start;
    endcase
  endfunction

  // Engine loopback, output-FIFO latency model and per-cycle compare
  always @(negedge clk) begin
    cycle++;
    if (!rst_n) begin
      sent_cks.delete(); wr_log.delete(); out_fifo.delete();
      rec_len = 0; s1 = 0; s2 = 0; csa_out_rdata = 0; csa_out_r_ready = 0;
      prev_full = 0; prev_wen = 0; abort_seen = 0;
    end else begin
      if (busy) check("jobs_sent_track", 64'(jobs_sent), 64'(sent_cks.size()));
      if (start && !busy) begin
        m_base = cfg_ck_base; m_block = cfg_block; m_times = cfg_times;
        m_times_start = cfg_times_start; m_target = cfg_target; m_stop_on_hit = cfg_stop_on_hit;
        sent_cks.delete(); wr_log.delete();
        rec_len = 0; abort_seen = 0; done_pulses = 0; start_cycle = cycle;
      end
      if (csa_in_wen) begin
        if (rec_len == 0) begin
          check("no_start_while_full", 64'(prev_full), 64'd0);
          check("no_start_after_abort", 64'(abort_seen), 64'd0);
          if (m_stop_on_hit) check("no_start_after_hit", 64'(hit), 64'd0);
        end else begin
          check("record_back_to_back", 64'(prev_wen), 64'd1);
        end
        check("wdata", 64'(csa_in_wdata), 64'(exp_word(sent_cks.size(), rec_len)));
        wr_log.push_back(csa_in_wdata);
        cur_rec[rec_len] = csa_in_wdata;
        rec_len++;
        if (rec_len == 5) begin
          rck  = {cur_rec[2][15:0], cur_rec[1]};
          rout = is_hit_ck(rck) ? m_target : ~m_target;
          for (int i = 0; i < 5; i++) out_fifo.push_back(cur_rec[i]);
          out_fifo.push_back(rout[31:0]);
          out_fifo.push_back(rout[63:32]);
          sent_cks.push_back(rck);
          rec_len = 0;
        end
      end else if (rec_len != 0) begin
        check("record_not_split", 64'(rec_len), 64'd0);
      end
      csa_out_rdata = s2;
      s2 = s1;
      s1 = 32'h0;
      if (csa_out_ren) begin
        check("ren_has_data", 64'(out_fifo.size() > 0), 64'd1);
        if (out_fifo.size() > 0) s1 = out_fifo.pop_front();
      end
      csa_out_r_ready = (out_fifo.size() >= 7);
      if (done) begin
        done_pulses++;
        done_cycle = cycle;
        exp_hits = 0;
        exp_hit_ck = '0;
        foreach (sent_cks[i]) begin
          if (is_hit_ck(sent_cks[i])) begin
            if (exp_hits == 0) exp_hit_ck = sent_cks[i];
            exp_hits++;
          end
        end
        check("done_busy_low", 64'(busy), 64'd0);
        check("done_jobs_sent", 64'(jobs_sent), 64'(sent_cks.size()));
        check("done_results", 64'(results_received), 64'(sent_cks.size()));
        check("done_hit_count", 64'(hit_count), 64'(exp_hits));
        check("done_hit", 64'(hit), 64'(exp_hits != 0));
        check("done_hit_ck", 64'(hit_ck), 64'(exp_hit_ck));
        check("done_drained", 64'(out_fifo.size()), 64'd0);
        check("done_no_partial", 64'(rec_len), 64'd0);
      end
      prev_full  = csa_in_full;
      prev_wen   = csa_in_wen;
      abort_seen = abort_seen | abort;
    end
  end

  task automatic run_sweep(input logic [47:0] base, input logic [31:0] cnt, input logic soh);
    @(posedge clk) #1;
    cfg_ck_base = base; cfg_job_count = cnt; cfg_stop_on_hit = soh; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_pulses == 0 && n < 3000) begin
      @(posedge clk) #1;
      n++;
    end
    check({name, "_done_seen"}, 64'(done_pulses > 0), 64'd1);
    repeat (6) @(posedge clk) #1;
    check({name, "_done_once"}, 64'(done_pulses), 64'd1);
  endtask

  task automatic wait_words(input int count);
    int n;
    n = 0;
    while (wr_log.size() < count && n < 500) begin
      @(posedge clk) #1;
      n++;
    end
    check("words_reached", 64'(wr_log.size() >= count), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 0; abort = 0; csa_in_full = 0;
    cfg_block = 32'hB10C_0001; cfg_times = 32'h0000_0010; cfg_times_start = 32'h0000_0003;
    cfg_job_count = 0; cfg_ck_base = 0; cfg_stop_on_hit = 0;
    cfg_target = 64'hDEAD_BEEF_0BAD_F00D;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wen", 64'(csa_in_wen), 64'd0);
    check("rst_ren", 64'(csa_out_ren), 64'd0);
    check("rst_busy_done", 64'({busy, done, hit}), 64'd0);
    check("rst_counters", {jobs_sent, results_received}, 64'd0);
    check("rst_hit_stats", {hit_count, 16'h0, hit_ck[47:32]} | 64'(hit_ck), 64'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;

    // Three jobs; engine matches only ck 0x1234_5679
    hit_set = '{48'h0000_1234_5679};
    run_sweep(48'h0000_1234_5678, 32'd3, 1'b0);
    wait_done("t1");
    check("t1_strobes", 64'(wr_log.size()), 64'd15);
    check("t1_job2_w1", 64'(wr_log[11]), 64'h1234_567A);
    check("t1_job2_w2", 64'(wr_log[12]), 64'h0000_0000);
    check("t1_jobs_sent", 64'(jobs_sent), 64'd3);
    check("t2_results", 64'(results_received), 64'd3);
    check("t2_hit", 64'(hit), 64'd1);
    check("t2_hit_count", 64'(hit_count), 64'd1);
    check("t2_hit_ck", 64'(hit_ck), 64'h0000_1234_5679);

    // ck wraps modulo 2^48
    hit_set.delete();
    run_sweep(48'hFFFF_FFFF_FFFF, 32'd2, 1'b0);
    wait_done("t3");
    check("t3_job0_w1", 64'(wr_log[1]), 64'hFFFF_FFFF);
    check("t3_job0_w2", 64'(wr_log[2]), 64'h0000_FFFF);
    check("t3_job1_w1", 64'(wr_log[6]), 64'h0000_0000);
    check("t3_job1_w2", 64'(wr_log[7]), 64'h0000_0000);
    check("t3_no_hit", 64'(hit), 64'd0);

    // Full raised inside a record must not split it; next job waits for full=0
    run_sweep(48'h0000_0000_0100, 32'd2, 1'b0);
    wait_words(2);
    csa_in_full = 1'b1;
    repeat (20) @(posedge clk) #1;
    check("t4_held_at_one_record", 64'(wr_log.size()), 64'd5);
    csa_in_full = 1'b0;
    wait_done("t4");
    check("t4_jobs_sent", 64'(jobs_sent), 64'd2);

    // Stop on first hit (job 1)
    hit_set = '{48'h0000_0000_1001};
    run_sweep(48'h0000_0000_1000, 32'd10, 1'b1);
    wait_done("t5");
    check("t5_hit_count", 64'(hit_count), 64'd1);
    check("t5_hit_ck", 64'(hit_ck), 64'h0000_0000_1001);
    check("t5_stopped_early", 64'(jobs_sent < 32'd10), 64'd1);

    // Abort during job 1's record: that record completes, nothing more is issued
    hit_set.delete();
    run_sweep(48'h0000_0000_2000, 32'd10, 1'b0);
    wait_words(7);
    abort = 1'b1;
    @(posedge clk) #1;
    abort = 1'b0;
    wait_done("abort");
    check("abort_jobs_sent", 64'(jobs_sent), 64'd2);

    // Zero jobs: done two cycles after start, no strobes
    run_sweep(48'h0000_0000_3000, 32'd0, 1'b0);
    wait_done("t6a");
    check("t6a_done_latency", 64'(done_cycle - start_cycle), 64'd2);
    check("t6a_no_strobes", 64'(wr_log.size()), 64'd0);

    // Reset while reading
    run_sweep(48'h0000_0000_4000, 32'd3, 1'b0);
    n = 0;
    while (!csa_out_ren && n < 500) begin
      @(posedge clk) #1;
      n++;
    end
    check("t6b_reached_read", 64'(csa_out_ren), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6b_ren_low", 64'(csa_out_ren), 64'd0);
    check("t6b_wen_low", 64'(csa_in_wen), 64'd0);
    check("t6b_flags", 64'({busy, done, hit}), 64'd0);
    check("t6b_counters", {jobs_sent, results_received}, 64'd0);
    check("t6b_hit_count", 64'(hit_count), 64'd0);
    check("t6b_hit_ck", 64'(hit_ck), 64'd0);
    repeat (2) @(posedge clk) #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk) #1;
    check("t6b_quiet_after", 64'({csa_in_wen, csa_out_ren, busy}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
